counter_ctrl: RTL and testbench

Sequencer for the demo counter datapath. Accepts commands over a valid/ready interface and generates the counter's step, direction and load strobes. Step pulses come from a programmable prescaler, with terminal-count wrap or one-shot stop. Sits between the pin-level command decode in the top module and the counter register, and uses the counter value as feedback.

---
 rtl/counter_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_counter_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// counter_ctrl: command sequencer for the demo counter datapath.
// Commands arrive over a valid/ready handshake. A programmable prescaler
// produces step ticks. At terminal count the counter either wraps (load)
// or stops (one-shot).
// Optional build macro: COUNTER_CTRL_WRAP_STATS_EN enables the saturating
// terminal-count statistics counter on wrap_count.
module counter_ctrl #(
   parameter int WIDTH = 8,
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [DIV_W-1:0] cmd_data,
   input  logic [WIDTH-1:0] cnt_value,
   output logic             cnt_en,
   output logic             cnt_up,
   output logic             cnt_load,
   output logic [WIDTH-1:0] cnt_load_val,
   output logic             tc_pulse,
   output logic [1:0]       state,
   output logic [7:0]       wrap_count
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, DONE = 2'd3} state_t;

   localparam logic [2:0] OP_START   = 3'd1;
   localparam logic [2:0] OP_STOP    = 3'd2;
   localparam logic [2:0] OP_PAUSE   = 3'd3;
   localparam logic [2:0] OP_RESUME  = 3'd4;
   localparam logic [2:0] OP_LOAD    = 3'd5;
   localparam logic [2:0] OP_SET_DIV = 3'd6;
   localparam logic [2:0] OP_SET_LIM = 3'd7;

   state_t             state_reg, state_next;
   logic [DIV_W-1:0]   div_reg, div_next;
   logic [DIV_W-1:0]   presc_reg, presc_next;
   logic [WIDTH-1:0]   limit_reg, limit_next;
   logic               up_reg, up_next;
   logic               oneshot_reg, oneshot_next;
   logic               en_reg, en_next;
   logic               load_reg, load_next;
   logic [WIDTH-1:0]   load_val_reg, load_val_next;
   logic               tc_reg, tc_next;

   logic               accept;
   logic               tick;
   logic               tick_ok;
   logic               terminal;
   logic [WIDTH-1:0]   eff_value;

   assign cmd_ready    = !load_reg;
   assign accept       = cmd_valid && cmd_ready;
   assign tick         = (state_reg == RUN) && (presc_reg == div_reg);

   assign cnt_en       = en_reg;
   assign cnt_up       = up_reg;
   assign cnt_load     = load_reg;
   assign cnt_load_val = load_val_reg;
   assign tc_pulse     = tc_reg;
   assign state        = state_reg;

   // The datapath applies our strobes one edge later, so cnt_value lags by
   // one cycle whenever a strobe is pending; project the value it will hold.
   always_comb begin
      eff_value = cnt_value;
      if (load_reg)
         eff_value = load_val_reg;
      else if (en_reg)
         eff_value = up_reg ? cnt_value + WIDTH'(1) : cnt_value - WIDTH'(1);
   end

   assign terminal = up_reg ? (eff_value == limit_reg) : (eff_value == '0);

   // Next-state and output decode: commands first, then the prescaler tick
   // unless a command that takes priority over it was accepted.
   always_comb begin
      state_next    = state_reg;
      div_next      = div_reg;
      limit_next    = limit_reg;
      up_next       = up_reg;
      oneshot_next  = oneshot_reg;
      presc_next    = presc_reg;
      en_next       = 1'b0;
      load_next     = 1'b0;
      load_val_next = load_val_reg;
      tc_next       = 1'b0;
      tick_ok       = tick;

      if (state_reg == RUN)
         presc_next = tick ? '0 : presc_reg + DIV_W'(1);

      if (accept) begin
         case (cmd_op)
            OP_START: begin
               up_next      = cmd_data[0];
               oneshot_next = cmd_data[1];
               presc_next   = '0;
               state_next   = RUN;
               tick_ok      = 1'b0;
            end
            OP_STOP: begin
               state_next = IDLE;
               presc_next = '0;
               tick_ok    = 1'b0;
            end
            OP_PAUSE: begin
               if (state_reg == RUN) begin
                  state_next = PAUSED;
                  presc_next = presc_reg;
                  tick_ok    = 1'b0;
               end
            end
            OP_RESUME: begin
               if (state_reg == PAUSED)
                  state_next = RUN;
            end
            OP_LOAD: begin
               load_next     = 1'b1;
               load_val_next = cmd_data[WIDTH-1:0];
               tick_ok       = 1'b0;
            end
            OP_SET_DIV: begin
               div_next   = cmd_data;
               presc_next = '0;
            end
            OP_SET_LIM: limit_next = cmd_data[WIDTH-1:0];
            default: ;
         endcase
      end

      if (tick_ok) begin
         if (!terminal) begin
            en_next = 1'b1;
         end else if (oneshot_reg) begin
            tc_next    = 1'b1;
            state_next = DONE;
         end else begin
            tc_next       = 1'b1;
            load_next     = 1'b1;
            load_val_next = up_reg ? '0 : limit_reg;
         end
      end
   end

   // State and registered outputs; reset aborts immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         div_reg      <= '0;
         limit_reg    <= '1;
         presc_reg    <= '0;
         up_reg       <= 1'b1;
         oneshot_reg  <= 1'b0;
         en_reg       <= 1'b0;
         load_reg     <= 1'b0;
         load_val_reg <= '0;
         tc_reg       <= 1'b0;
      end else begin
         state_reg    <= state_next;
         div_reg      <= div_next;
         limit_reg    <= limit_next;
         presc_reg    <= presc_next;
         up_reg       <= up_next;
         oneshot_reg  <= oneshot_next;
         en_reg       <= en_next;
         load_reg     <= load_next;
         load_val_reg <= load_val_next;
         tc_reg       <= tc_next;
      end
   end

`ifdef COUNTER_CTRL_WRAP_STATS_EN
   logic [7:0] wrap_reg;

   // Saturating terminal-count counter, kept in step with tc_pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wrap_reg <= '0;
      else if (accept && cmd_op == OP_START)
         wrap_reg <= '0;
      else if (tc_next && wrap_reg != 8'hFF)
         wrap_reg <= wrap_reg + 8'd1;
   end

   assign wrap_count = wrap_reg;
`else
   assign wrap_count = '0;
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed scoreboard bench for counter_ctrl. Stimulus pushes
// hand-computed strobe events (cycle, strobes, state); a monitor pops and
// compares one event whenever the DUT raises cnt_en, cnt_load or tc_pulse.
module tb_counter_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = 3'd0;
   logic [15:0] cmd_data = 16'd0;
   logic [7:0]  cnt_value;
   logic        cnt_en, cnt_up, cnt_load, tc_pulse;
   logic [7:0]  cnt_load_val;
   logic [1:0]  state;
   logic [7:0]  wrap_count;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int         cyc;
      logic       en;
      logic       load;
      logic [7:0] val;
      logic       tc;
      logic       up;
      logic [1:0] st;
      logic       rdy;
   } ev_t;

   ev_t exp_q[$];

   counter_ctrl #(.WIDTH(8), .DIV_W(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data),
      .cnt_value(cnt_value),
      .cnt_en(cnt_en), .cnt_up(cnt_up),
      .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
      .tc_pulse(tc_pulse), .state(state), .wrap_count(wrap_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Counter datapath model driven by the DUT strobes.
   always @(posedge clk or posedge rst) begin
      if (rst)
         cnt_value <= 8'd0;
      else if (cnt_load)
         cnt_value <= cnt_load_val;
      else if (cnt_en)
         cnt_value <= cnt_up ? cnt_value + 8'd1 : cnt_value - 8'd1;
   end

   // Monitor: every strobe cycle must match the next expected event.
   always @(negedge clk) begin
      #1;
      if (!rst && (cnt_en || cnt_load || tc_pulse)) begin
         ev_t e;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event cyc=%0d en=%0b load=%0b val=%0h tc=%0b state=%0d, required no event",
                     cyc, cnt_en, cnt_load, cnt_load_val, tc_pulse, state);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.en != cnt_en || e.load != cnt_load ||
                (e.load && e.val != cnt_load_val) || e.tc != tc_pulse ||
                e.up != cnt_up || e.st != state || e.rdy != cmd_ready) begin
               n_fail++;
               $display("FAIL event got cyc=%0d en=%0b load=%0b val=%0h tc=%0b up=%0b st=%0d rdy=%0b, required cyc=%0d en=%0b load=%0b val=%0h tc=%0b up=%0b st=%0d rdy=%0b",
                        cyc, cnt_en, cnt_load, cnt_load_val, tc_pulse, cnt_up, state, cmd_ready,
                        e.cyc, e.en, e.load, e.val, e.tc, e.up, e.st, e.rdy);
            end else begin
               $display("event cyc=%0d en=%0b load=%0b val=%0h tc=%0b st=%0d ok",
                        cyc, cnt_en, cnt_load, cnt_load_val, tc_pulse, state);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired at cyc=%0d, required completion", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s got %0h required %0h", name, act, req);
      end else begin
         $display("check %s = %0h ok", name, act);
      end
   endtask

   task automatic push(input int c, input logic en, input logic load, input logic [7:0] val,
                       input logic tc, input logic up, input logic [1:0] st);
      ev_t e;
      e.cyc = c; e.en = en; e.load = load; e.val = val;
      e.tc = tc; e.up = up; e.st = st; e.rdy = !load;
      exp_q.push_back(e);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge,
   // with acc = the cycle number of that accepting edge.
   task automatic send(input logic [2:0] op, input logic [15:0] data, output int acc);
      int waits = 0;
      while (!cmd_ready && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      if (!cmd_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL cmd_ready_timeout got 0 required 1 op=%0d", op);
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      acc       = cyc;
      $display("cmd op=%0d data=%0h accepted cyc=%0d", op, data, acc);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   initial begin
      int a, r, l;
      logic [7:0] wrap_req;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("reset_state", state, 0);
      check("reset_cnt_up", cnt_up, 1);
      check("reset_strobes", {cnt_en, cnt_load, tc_pulse}, 0);
      check("reset_load_val", cnt_load_val, 0);
      check("reset_wrap", wrap_count, 0);
      check("reset_ready", cmd_ready, 1);
      rst = 1'b0;
      @(negedge clk);

      // Wrap mode up, div 0, limit 5: 5 steps then wrap load, period 6
      send(3'd7, 16'd5, a);
      send(3'd1, 16'd1, a);
      for (int k = 1; k <= 11; k++) begin
         if (k == 6) push(a + k, 0, 1, 8'd0, 1, 1, 2'd1);
         else        push(a + k, 1, 0, 8'd0, 0, 1, 2'd1);
      end
      wait_cyc(a + 11);
      send(3'd2, 16'd0, a);
      check("stop_state", state, 0);

      // div 3: tick every 4 cycles; pause freezes the prescaler
      send(3'd7, 16'd200, a);
      send(3'd6, 16'd3, a);
      send(3'd1, 16'd1, a);
      push(a + 4, 1, 0, 8'd0, 0, 1, 2'd1);
      push(a + 8, 1, 0, 8'd0, 0, 1, 2'd1);
      wait_cyc(a + 9);
      send(3'd3, 16'd0, l);
      check("pause_state", state, 2);
      wait_cyc(a + 19);
      send(3'd4, 16'd0, r);
      check("resume_state", state, 1);
      push(r + 3, 1, 0, 8'd0, 0, 1, 2'd1);
      push(r + 7, 1, 0, 8'd0, 0, 1, 2'd1);
      wait_cyc(r + 7);
      send(3'd2, 16'd0, a);

      // One-shot down from 3 with limit 9, div 1
      send(3'd7, 16'd9, a);
      send(3'd6, 16'd1, a);
      l = cyc + 1;
      push(l, 0, 1, 8'd3, 0, 1, 2'd0);
      send(3'd5, 16'd3, l);
      send(3'd1, 16'd2, a);
      push(a + 2, 1, 0, 8'd0, 0, 0, 2'd1);
      push(a + 4, 1, 0, 8'd0, 0, 0, 2'd1);
      push(a + 6, 1, 0, 8'd0, 0, 0, 2'd1);
      push(a + 8, 0, 0, 8'd0, 1, 0, 2'd3);
      wait_cyc(a + 14);
      check("oneshot_done_state", state, 3);
      check("oneshot_cnt_value", cnt_value, 0);

      // LOAD accepted on the edge where a tick fires: load wins
      send(3'd6, 16'd2, a);
      send(3'd7, 16'd200, a);
      send(3'd1, 16'd1, a);
      push(a + 3, 1, 0, 8'd0, 0, 1, 2'd1);
      push(a + 6, 0, 1, 8'h7A, 0, 1, 2'd1);
      push(a + 9, 1, 0, 8'd0, 0, 1, 2'd1);
      wait_cyc(a + 5);
      send(3'd5, 16'h007A, l);
      wait_cyc(a + 9);
      check("load_cnt_value", cnt_value, 8'h7A);
      send(3'd2, 16'd0, l);

      // Asynchronous reset mid-run
      send(3'd6, 16'd0, a);
      send(3'd1, 16'd1, a);
      for (int k = 1; k <= 3; k++) push(a + k, 1, 0, 8'd0, 0, 1, 2'd1);
      wait_cyc(a + 3);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_state", state, 0);
      check("async_rst_strobes", {cnt_en, cnt_load, tc_pulse}, 0);
      check("async_rst_up", cnt_up, 1);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check("post_rst_state", state, 0);

      // Wrap statistics: 300 wraps with limit 0
      send(3'd7, 16'd0, a);
      send(3'd6, 16'd1, a);
      send(3'd1, 16'd1, a);
      for (int k = 1; k <= 300; k++) push(a + 2 * k, 0, 1, 8'd0, 1, 1, 2'd1);
      wait_cyc(a + 600);
      send(3'd2, 16'd0, l);
`ifdef COUNTER_CTRL_WRAP_STATS_EN
      wrap_req = 8'd255;
`else
      wrap_req = 8'd0;
`endif
      check("wrap_count_saturated", wrap_count, wrap_req);
      send(3'd6, 16'hFFFF, a);
      send(3'd1, 16'd1, a);
      check("wrap_count_start_clear", wrap_count, 0);
      send(3'd2, 16'd0, a);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
